// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and main-memory bus signals around mem_arbiter
interface mem_arbiter_if #(
    parameter int AW = 27,
    parameter int DW = 32
) ();
    logic          swc;

    logic          wb_req;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_data;
    logic [3:0]    wb_byteen;
    logic          wb_gnt;
    logic          wb_done;

    logic          d_req;
    logic [AW-1:0] d_adr;
    logic          d_gnt;
    logic          d_done;

    logic          i_req;
    logic [AW-1:0] i_adr;
    logic          i_gnt;
    logic          i_done;

    logic [DW-1:0] rdata;
    logic          timeout_err;

    logic [AW-1:0] memadr;
    logic [DW-1:0] memwdata;
    logic [3:0]    membyteen;
    logic          memrwb;
    logic          memen;
    logic [DW-1:0] memrdata;
    logic          memdone;

    modport master (
        input  swc,
        input  wb_req, wb_adr, wb_data, wb_byteen,
        output wb_gnt, wb_done,
        input  d_req, d_adr,
        output d_gnt, d_done,
        input  i_req, i_adr,
        output i_gnt, i_done,
        output rdata, timeout_err,
        output memadr, memwdata, membyteen, memrwb, memen,
        input  memrdata, memdone
    );

    modport slave (
        output swc,
        output wb_req, wb_adr, wb_data, wb_byteen,
        input  wb_gnt, wb_done,
        output d_req, d_adr,
        input  d_gnt, d_done,
        output i_req, i_adr,
        input  i_gnt, i_done,
        input  rdata, timeout_err,
        input  memadr, memwdata, membyteen, memrwb, memen,
        output memrdata, memdone
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority main-memory arbiter with anti-starvation and bus timeout
module mem_arbiter #(
    parameter int AW           = 27,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          ph1,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_WB   = 2'b01,
        OWN_D    = 2'b10,
        OWN_I    = 2'b11
    } owner_t;

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]      TOUT_LAST  = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [AW-1:0] memadr_q, memadr_d;
    logic [DW-1:0] memwdata_q, memwdata_d;
    logic [3:0]    membyteen_q, membyteen_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    tout_q, tout_d;
    logic          abort_q, abort_d;

    logic   read_pend;
    logic   prim_req;
    logic   starved;
    owner_t prim_own;
    owner_t sec_own;

    // swc only swaps which read port is primary; the latched owner is unaffected.
    always_comb begin
        read_pend = bus.d_req | bus.i_req;
        prim_req  = bus.swc ? bus.i_req : bus.d_req;
        prim_own  = bus.swc ? OWN_I : OWN_D;
        sec_own   = bus.swc ? OWN_D : OWN_I;
        starved   = (starve_q == STARVE_MAX) && read_pend;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        memadr_d    = memadr_q;
        memwdata_d  = memwdata_q;
        membyteen_d = membyteen_q;
        rdata_d     = rdata_q;
        starve_d    = starve_q;
        tout_d      = tout_q;
        abort_d     = abort_q;
        case (state_q)
            IDLE: begin
                if (bus.wb_req && !starved) begin
                    owner_d     = OWN_WB;
                    memadr_d    = bus.wb_adr;
                    memwdata_d  = bus.wb_data;
                    membyteen_d = bus.wb_byteen;
                    if (!read_pend)
                        starve_d = '0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + 1'b1;
                    tout_d      = '0;
                    abort_d     = 1'b0;
                    state_d     = BUSY;
                end else if (read_pend) begin
                    owner_d     = prim_req ? prim_own : sec_own;
                    memadr_d    = (owner_d == OWN_I) ? bus.i_adr : bus.d_adr;
                    memwdata_d  = '0;
                    membyteen_d = 4'b1111;
                    starve_d    = '0;
                    tout_d      = '0;
                    abort_d     = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                tout_d = tout_q + 8'd1;
                // memdone wins over a timeout landing on the same cycle.
                if (bus.memdone) begin
                    if (owner_q != OWN_WB)
                        rdata_d = bus.memrdata;
                    state_d = DONE;
                end else if (tout_q == TOUT_LAST) begin
                    if (owner_q != OWN_WB)
                        rdata_d = '0;
                    abort_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                owner_d = OWN_NONE;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            memadr_q    <= '0;
            memwdata_q  <= '0;
            membyteen_q <= '0;
            rdata_q     <= '0;
            starve_q    <= '0;
            tout_q      <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            memadr_q    <= memadr_d;
            memwdata_q  <= memwdata_d;
            membyteen_q <= membyteen_d;
            rdata_q     <= rdata_d;
            starve_q    <= starve_d;
            tout_q      <= tout_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.memen       = (state_q == BUSY);
    assign bus.memrwb      = !((state_q == BUSY) && (owner_q == OWN_WB));
    assign bus.memadr      = memadr_q;
    assign bus.memwdata    = memwdata_q;
    assign bus.membyteen   = membyteen_q;
    assign bus.rdata       = rdata_q;
    assign bus.wb_gnt      = (state_q == BUSY) && (owner_q == OWN_WB);
    assign bus.d_gnt       = (state_q == BUSY) && (owner_q == OWN_D);
    assign bus.i_gnt       = (state_q == BUSY) && (owner_q == OWN_I);
    assign bus.wb_done     = (state_q == DONE) && (owner_q == OWN_WB);
    assign bus.d_done      = (state_q == DONE) && (owner_q == OWN_D);
    assign bus.i_done      = (state_q == DONE) && (owner_q == OWN_I);
    assign bus.timeout_err = (state_q == DONE) && abort_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 27, DW = 32, STARVE_LIMIT = 4, TIMEOUT = 255;
    localparam int OWN_WB = 1, OWN_D = 2, OWN_I = 3;
    localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;

    logic ph1   = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    int            mem_lat = 2;
    int            busy_cycles = 0;
    logic [DW-1:0] rd_word, last_word, ref_rdata;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .ph1  (ph1),
        .reset(reset),
        .bus  (bus)
    );

    always #5 ph1 = ~ph1;

    // Memory responder: answers on BUSY cycle mem_lat (0 = never), random noise otherwise.
    task automatic tick();
        @(negedge ph1);
        if (bus.memen === 1'b1) begin
            busy_cycles++;
            if (mem_lat != 0 && busy_cycles == mem_lat) begin
                bus.memdone  = 1'b1;
                bus.memrdata = rd_word;
                last_word    = rd_word;
                rd_word      = $urandom;
            end else begin
                bus.memdone  = 1'b0;
                bus.memrdata = $urandom;
            end
        end else begin
            busy_cycles  = 0;
            bus.memdone  = 1'($urandom_range(0, 1));
            bus.memrdata = $urandom;
        end
    endtask

    function automatic int model_pick(bit w, bit d, bit i, bit s, int starve);
        if (w && !((d || i) && starve == STARVE_LIMIT)) return OWN_WB;
        if (s ? i : d) return s ? OWN_I : OWN_D;
        if (s ? d : i) return s ? OWN_D : OWN_I;
        return 0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({bus.memen, bus.memrwb, bus.wb_gnt, bus.d_gnt, bus.i_gnt, bus.wb_done, bus.d_done,
             bus.i_done, bus.timeout_err} !== 9'b0_1_000_000_0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b expected 010000000", {bus.memen, bus.memrwb, bus.wb_gnt,
                     bus.d_gnt, bus.i_gnt, bus.wb_done, bus.d_done, bus.i_done, bus.timeout_err});
        end
        vectors++;
        if ({bus.memadr, bus.memwdata, bus.membyteen} !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: got adr %h wdata %h be %b expected all zero",
                     bus.memadr, bus.memwdata, bus.membyteen);
        end
        vectors++;
        if (bus.rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected 0", bus.rdata);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus.memen !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: got memen %b expected 0", bus.memen);
        end
    endtask

    task automatic test_single_read();
        int gnt_cyc = 0, done_cyc = 0, other = 0;
        bus.swc = 1'b0; mem_lat = 2; rd_word = 32'hBEADBEEF;
        bus.d_adr = 27'h0AD; bus.d_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            other += int'(bus.wb_gnt | bus.i_gnt | bus.wb_done | bus.i_done | bus.timeout_err);
            if (n == 0) begin
                vectors++;
                if (bus.d_gnt !== 1'b1) begin
                    miscompares++;
                    $display("FAIL read_latency: got d_gnt %b expected 1", bus.d_gnt);
                end
            end
            if (bus.d_gnt === 1'b1) begin
                gnt_cyc++;
                vectors++;
                if ({bus.memadr, bus.memrwb, bus.membyteen, bus.memen} !== {27'h0AD, 1'b1, 4'b1111, 1'b1}) begin
                    miscompares++;
                    $display("FAIL read_bus: got adr %h rwb %b be %b en %b expected 0ad 1 1111 1",
                             bus.memadr, bus.memrwb, bus.membyteen, bus.memen);
                end
            end
            if (bus.d_done === 1'b1) begin
                done_cyc++;
                bus.d_req = 1'b0;
                vectors++;
                if ({bus.memen, bus.rdata} !== {1'b0, 32'hBEADBEEF}) begin
                    miscompares++;
                    $display("FAIL read_rdata: got en %b rdata %h expected 0 beadbeef", bus.memen, bus.rdata);
                end
            end
        end
        vectors++;
        if ({gnt_cyc, done_cyc, other} !== {32'd2, 32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL read_counts: got gnt %0d done %0d stray %0d expected 2 1 0", gnt_cyc, done_cyc, other);
        end
    endtask

    task automatic test_write();
        int done_cyc = 0, gnt_cyc = 0;
        mem_lat = 3;
        bus.wb_adr = 27'h4AD; bus.wb_data = 32'h21212121; bus.wb_byteen = 4'b0011; bus.wb_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.wb_gnt === 1'b1) begin
                gnt_cyc++;
                vectors++;
                if ({bus.memadr, bus.memwdata, bus.membyteen, bus.memrwb, bus.d_gnt, bus.i_gnt} !==
                    {27'h4AD, 32'h21212121, 4'b0011, 3'b000}) begin
                    miscompares++;
                    $display("FAIL write_bus: got adr %h wdata %h be %b rwb %b expected 4ad 21212121 0011 0",
                             bus.memadr, bus.memwdata, bus.membyteen, bus.memrwb);
                end
            end
            if (bus.wb_done === 1'b1) begin
                done_cyc++;
                bus.wb_req = 1'b0;
                vectors++;
                if (bus.rdata !== 32'hBEADBEEF) begin
                    miscompares++;
                    $display("FAIL write_rdata_kept: got %h expected beadbeef", bus.rdata);
                end
            end
        end
        vectors++;
        if ({gnt_cyc, done_cyc} !== {32'd3, 32'd1}) begin
            miscompares++;
            $display("FAIL write_counts: got gnt %0d done %0d expected 3 1", gnt_cyc, done_cyc);
        end
    endtask

    task automatic test_priority(input bit s);
        int order[$];
        int exp_order[3];
        exp_order[0] = OWN_WB;
        exp_order[1] = s ? OWN_I : OWN_D;
        exp_order[2] = s ? OWN_D : OWN_I;
        bus.swc = s; mem_lat = $urandom_range(1, 3);
        bus.wb_adr = AW'($urandom); bus.d_adr = AW'($urandom); bus.i_adr = AW'($urandom);
        bus.wb_req = 1'b1; bus.d_req = 1'b1; bus.i_req = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            vectors++;
            if ($countones({bus.wb_gnt, bus.d_gnt, bus.i_gnt}) > 1) begin
                miscompares++;
                $display("FAIL prio_onehot: got gnts %b expected at most one", {bus.wb_gnt, bus.d_gnt, bus.i_gnt});
            end
            if (bus.wb_done === 1'b1) begin order.push_back(OWN_WB); bus.wb_req = 1'b0; end
            if (bus.d_done === 1'b1)  begin order.push_back(OWN_D);  bus.d_req = 1'b0;  end
            if (bus.i_done === 1'b1)  begin order.push_back(OWN_I);  bus.i_req = 1'b0;  end
        end
        vectors++;
        if (order.size() != 3) begin
            miscompares++;
            $display("FAIL prio_count swc=%0d: got %0d completions expected 3", s, order.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (order[k] != exp_order[k]) begin
                    miscompares++;
                    $display("FAIL prio_order swc=%0d slot %0d: got owner %0d expected %0d", s, k, order[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int exp_seq[$] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 2};
        int got[$];
        bit rearm = 1'b0;
        int d_seen = 0;
        bus.swc = 1'b0; mem_lat = 1;
        bus.wb_req = 1'b1; bus.d_req = 1'b1;
        for (int n = 0; n < 200 && d_seen < 2; n++) begin
            tick();
            if (bus.wb_gnt === 1'b1 && rearm) begin bus.d_req = 1'b1; rearm = 1'b0; end
            if (bus.wb_done === 1'b1) got.push_back(OWN_WB);
            if (bus.d_done === 1'b1) begin
                got.push_back(OWN_D);
                d_seen++;
                bus.d_req = 1'b0;
                rearm = 1'b1;
            end
        end
        bus.wb_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) tick();
        vectors++;
        if (got.size() != exp_seq.size()) begin
            miscompares++;
            $display("FAIL starve_len: got %0d grants expected %0d", got.size(), exp_seq.size());
        end else begin
            for (int k = 0; k < exp_seq.size(); k++) begin
                vectors++;
                if (got[k] != exp_seq[k]) begin
                    miscompares++;
                    $display("FAIL starve_seq slot %0d: got owner %0d expected %0d", k, got[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int busy = 0, done_cyc = 0, rd_done = 0;
        bus.swc = 1'($urandom_range(0, 1)); mem_lat = 0;
        bus.i_adr = AW'($urandom); bus.i_req = 1'b1;
        for (int n = 0; n < 300 && done_cyc == 0; n++) begin
            tick();
            if (bus.memen === 1'b1) busy++;
            if (bus.i_done === 1'b1) begin
                done_cyc++;
                bus.i_req = 1'b0;
                vectors++;
                if ({bus.timeout_err, bus.memen, bus.rdata} !== {1'b1, 1'b0, 32'h0}) begin
                    miscompares++;
                    $display("FAIL tout_done: got err %b en %b rdata %h expected 1 0 0",
                             bus.timeout_err, bus.memen, bus.rdata);
                end
            end
        end
        vectors++;
        if ({busy, done_cyc} !== {TIMEOUT, 32'd1}) begin
            miscompares++;
            $display("FAIL tout_len: got busy %0d done %0d expected %0d 1", busy, done_cyc, TIMEOUT);
        end
        mem_lat = 2; bus.d_adr = AW'($urandom); bus.d_req = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (bus.d_done === 1'b1) begin
                rd_done++;
                bus.d_req = 1'b0;
                vectors++;
                if ({bus.timeout_err, bus.rdata} !== {1'b0, last_word}) begin
                    miscompares++;
                    $display("FAIL tout_recover: got err %b rdata %h expected 0 %h", bus.timeout_err, bus.rdata, last_word);
                end
            end
        end
        ref_rdata = last_word;
        vectors++;
        if (rd_done != 1) begin
            miscompares++;
            $display("FAIL tout_recover_count: got %0d expected 1", rd_done);
        end
    endtask

    task automatic test_random();
        int ph = P_IDLE, own = 0, starve = 0, pick;
        logic [AW-1:0] e_adr = '0;
        logic [DW-1:0] e_wdata = '0;
        logic [3:0]    e_be = '0;
        logic [DW-1:0] e_rdata = ref_rdata;
        logic [7:0]    exp_ctl;
        for (int n = 0; n < 1500; n++) begin
            int nxt;
            tick();
            exp_ctl = {ph == P_BUSY,
                       ph == P_BUSY && own == OWN_WB, ph == P_BUSY && own == OWN_D, ph == P_BUSY && own == OWN_I,
                       ph == P_DONE && own == OWN_WB, ph == P_DONE && own == OWN_D, ph == P_DONE && own == OWN_I,
                       1'b0};
            vectors++;
            if ({bus.memen, bus.wb_gnt, bus.d_gnt, bus.i_gnt, bus.wb_done, bus.d_done, bus.i_done,
                 bus.timeout_err} !== exp_ctl) begin
                miscompares++;
                $display("FAIL rand_ctl cycle %0d: got %b expected %b", n, {bus.memen, bus.wb_gnt, bus.d_gnt,
                         bus.i_gnt, bus.wb_done, bus.d_done, bus.i_done, bus.timeout_err}, exp_ctl);
            end
            nxt = ph;
            if (ph == P_BUSY) begin
                vectors++;
                if ({bus.memadr, bus.memwdata, bus.membyteen, bus.memrwb} !== {e_adr, e_wdata, e_be, own != OWN_WB}) begin
                    miscompares++;
                    $display("FAIL rand_bus cycle %0d: got adr %h wd %h be %b rwb %b expected %h %h %b %b", n,
                             bus.memadr, bus.memwdata, bus.membyteen, bus.memrwb, e_adr, e_wdata, e_be, own != OWN_WB);
                end
                if (bus.memdone === 1'b1) begin
                    nxt = P_DONE;
                    if (own != OWN_WB) e_rdata = bus.memrdata;
                end
                if ($urandom_range(0, 7) == 0) begin
                    if (own == OWN_WB) bus.wb_req = 1'b0;
                    if (own == OWN_D)  bus.d_req = 1'b0;
                    if (own == OWN_I)  bus.i_req = 1'b0;
                end
            end else if (ph == P_DONE) begin
                vectors++;
                if (bus.rdata !== e_rdata) begin
                    miscompares++;
                    $display("FAIL rand_rdata cycle %0d: got %h expected %h", n, bus.rdata, e_rdata);
                end
                if (own == OWN_WB) bus.wb_req = 1'b0;
                if (own == OWN_D)  bus.d_req = 1'b0;
                if (own == OWN_I)  bus.i_req = 1'b0;
                nxt = P_IDLE;
            end
            if (n < 1400) begin
                if (!bus.wb_req && !(ph != P_IDLE && own == OWN_WB) && $urandom_range(0, 3) == 0) begin
                    bus.wb_req = 1'b1; bus.wb_adr = AW'($urandom); bus.wb_data = $urandom; bus.wb_byteen = 4'($urandom);
                end
                if (!bus.d_req && !(ph != P_IDLE && own == OWN_D) && $urandom_range(0, 3) == 0) begin
                    bus.d_req = 1'b1; bus.d_adr = AW'($urandom);
                end
                if (!bus.i_req && !(ph != P_IDLE && own == OWN_I) && $urandom_range(0, 3) == 0) begin
                    bus.i_req = 1'b1; bus.i_adr = AW'($urandom);
                end
            end
            if ($urandom_range(0, 3) == 0) bus.swc = ~bus.swc;
            if (ph == P_IDLE) begin
                pick = model_pick(bus.wb_req, bus.d_req, bus.i_req, bus.swc, starve);
                if (pick != 0) begin
                    if (pick == OWN_WB)
                        starve = (bus.d_req || bus.i_req) ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
                    else
                        starve = 0;
                    own     = pick;
                    e_adr   = (pick == OWN_WB) ? bus.wb_adr : (pick == OWN_D) ? bus.d_adr : bus.i_adr;
                    e_wdata = (pick == OWN_WB) ? bus.wb_data : '0;
                    e_be    = (pick == OWN_WB) ? bus.wb_byteen : 4'b1111;
                    mem_lat = $urandom_range(1, 4);
                    nxt     = P_BUSY;
                end
            end
            ph = nxt;
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0, rd_done = 0;
        logic [AW-1:0] adr;
        mem_lat = 0; bus.wb_adr = AW'($urandom); bus.wb_req = 1'b1;
        repeat (5) tick();
        vectors++;
        if (bus.wb_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got wb_gnt %b expected 1", bus.wb_gnt);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.memen, bus.wb_gnt, bus.d_gnt, bus.i_gnt} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_async: got en/gnts %b expected 0000", {bus.memen, bus.wb_gnt, bus.d_gnt, bus.i_gnt});
        end
        adr = AW'($urandom);
        bus.wb_req = 1'b0; bus.d_adr = adr; bus.d_req = 1'b1;
        repeat (3) begin
            tick();
            stray += int'(bus.wb_done | bus.d_done | bus.i_done | bus.memen);
        end
        reset = 1'b0; mem_lat = 1;
        tick();
        vectors++;
        if ({bus.d_gnt, bus.memadr} !== {1'b1, adr}) begin
            miscompares++;
            $display("FAIL rstmid_regrant: got gnt %b adr %h expected 1 %h", bus.d_gnt, bus.memadr, adr);
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            stray += int'(bus.wb_done | bus.i_done);
            if (bus.d_done === 1'b1) begin rd_done++; bus.d_req = 1'b0; end
        end
        vectors++;
        if ({stray, rd_done} !== {32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL rstmid_done: got stray %0d d_done %0d expected 0 1", stray, rd_done);
        end
    endtask

    initial begin
        bus.swc = 1'b0;
        bus.wb_req = 1'b0; bus.wb_adr = '0; bus.wb_data = '0; bus.wb_byteen = '0;
        bus.d_req = 1'b0; bus.d_adr = '0;
        bus.i_req = 1'b0; bus.i_adr = '0;
        bus.memdone = 1'b0; bus.memrdata = '0;
        rd_word = $urandom; last_word = '0; ref_rdata = '0;
        test_reset();
        test_single_read();
        test_write();
        test_priority(1'b0);
        test_priority(1'b1);
        test_starvation();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
